// File: rtl/mips_exec_sequencer.sv
// mips_exec_sequencer: multi-cycle controller for the MIPS single-instruction
// datapath. Owns the 32x32 register file and sequences one instruction per
// IDLE -> DECODE -> EXEC -> WB pass against an external combinational ALU.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr                      R/I-type instruction word
//   alu_a, alu_b               registered operands (rs; rt or sext imm16)
//   alu_funct/opcode/shamt     fields of the captured instruction
//   alu_result                 combinational ALU output
//   result, result_valid       registered result, one-cycle pulse in WB
//   err_illegal_dst, err_clr   sticky illegal-destination flag and its clear
//   busy                       high outside IDLE
//   instr_count                completed-instruction counter (wraps)
//   dbg_we/dbg_addr/dbg_wdata  register-file preload port, honoured in IDLE
module mips_exec_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_funct,
  output logic [5:0]       alu_opcode,
  output logic [4:0]       alu_shamt,
  input  logic [31:0]      alu_result,
  output logic [31:0]      result,
  output logic             result_valid,
  output logic             err_illegal_dst,
  input  logic             err_clr,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count,
  input  logic             dbg_we,
  input  logic [4:0]       dbg_addr,
  input  logic [31:0]      dbg_wdata
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t            state;
  logic [31:0]       instr_q;
  logic [31:0][31:0] rf;        // rf[0] is never written, so it reads 0
  logic [4:0]        dst_q;
  logic              illegal_q;

  logic        r_type;
  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] rs_val, rt_val, imm_sext;

  assign r_type   = (instr_q[31:26] == 6'd0);
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign dst      = r_type ? rd : rt;
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];

  // ALU control comes straight from the captured word; it is stable from
  // DECODE onward because instr_q only loads in IDLE.
  assign alu_funct  = instr_q[5:0];
  assign alu_opcode = instr_q[31:26];
  assign alu_shamt  = instr_q[10:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      instr_q         <= '0;
      rf              <= '0;
      dst_q           <= '0;
      illegal_q       <= 1'b0;
      alu_a           <= '0;
      alu_b           <= '0;
      result          <= '0;
      result_valid    <= 1'b0;
      err_illegal_dst <= 1'b0;
      instr_count     <= '0;
      instr_ready     <= 1'b1;
      busy            <= 1'b0;
    end else begin
      // Clear first so a same-edge error set below takes priority.
      if (err_clr) err_illegal_dst <= 1'b0;
      case (state)
        IDLE: begin
          // Preload and acceptance may share an edge; operands are read in
          // DECODE, so the new instruction sees the preloaded value.
          if (dbg_we && dbg_addr != 5'd0) rf[dbg_addr] <= dbg_wdata;
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          alu_a     <= rs_val;
          alu_b     <= r_type ? rt_val : imm_sext;
          dst_q     <= dst;
          // $0 is hardwired, $26/$27 are reserved for the kernel.
          illegal_q <= (dst == 5'd0) || (dst == 5'd26) || (dst == 5'd27);
          state     <= EXEC;
        end
        EXEC: begin
          result       <= alu_result;
          result_valid <= 1'b1;
          if (illegal_q) err_illegal_dst <= 1'b1;
          else           rf[dst_q]       <= alu_result;
          instr_count  <= instr_count + 1'b1;
          state        <= WB;
        end
        WB: begin
          result_valid <= 1'b0;
          instr_ready  <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
